// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for the snake game.
// Owns the IDLE/PLAY/PAUSE/OVER play-state machine. Turns refresh_tick into
// move_en step pulses, filters direction requests, pulses game_clr on restart,
// and derives score/win from the datapath's square count and collision status.
// Optional feature macro: SPEEDUP_EN. When it is defined, the step divider
// shrinks as the score grows. It never drops below MIN_DIV, and it changes only
// at a counter wrap.
module game_ctrl #(
  parameter int STEP_DIV    = 8,
  parameter int INIT_LEN    = 3,
  parameter int MAX_SQUARES = 33,
  parameter int MIN_DIV     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  input  logic       status,
  input  logic [5:0] num_squares,
  output logic       move_en,
  output logic [1:0] dir,
  output logic       game_clr,
  output logic [1:0] state,
  output logic [7:0] score,
  output logic       win
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [1:0] DIR_RIGHT  = 2'd1;
  localparam logic [7:0] STEP_DIV_W = 8'(STEP_DIV);
  localparam logic [8:0] INIT_LEN_W = 9'(INIT_LEN);
  localparam logic [6:0] MAX_SQ_W   = 7'(MAX_SQUARES);

  // Reject divider settings the 8-bit step counter cannot honour.
  if (STEP_DIV < 1 || STEP_DIV > 255 || MIN_DIV < 1) begin : g_bad_param
    $error("game_ctrl: STEP_DIV must be 1..255 and MIN_DIV must be >= 1");
  end

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] dir_q, dir_d;
  logic       move_en_q, move_en_d;
  logic       game_clr_q, game_clr_d;
  logic [7:0] score_q, score_d;
  logic       win_q, win_d;

  logic [7:0] div_q;        // effective refresh_ticks per step
  logic [8:0] sq_diff;
  logic [7:0] score_calc;
  logic       start_game;
  logic       dir_accept;

  assign start_game = (state_q == S_IDLE) && btn_start;
  // Flipping bit 1 of a direction gives its exact reverse (up<->down, right<->left).
  assign dir_accept = dir_valid && (dir_req != (dir_q ^ 2'b10));

  // Score from the square count: clamped at 0 below INIT_LEN, saturated at 255.
  always_comb begin
    sq_diff = {3'b000, num_squares} - INIT_LEN_W;
    if ({3'b000, num_squares} < INIT_LEN_W) begin
      score_calc = '0;
    end else if (sq_diff > 9'd255) begin
      score_calc = 8'hFF;
    end else begin
      score_calc = sq_diff[7:0];
    end
  end

`ifdef SPEEDUP_EN
  localparam logic [8:0] MIN_DIV_W = 9'(MIN_DIV);
  logic [7:0] div_d;
  logic [8:0] slow_by;

  // Next divider: one tick shorter per 8 points of score, floored at MIN_DIV.
  // It is loaded only on a wrap or a restart, so a step in progress keeps its length.
  always_comb begin
    slow_by = {4'b0000, score_q[7:3]};
    div_d   = div_q;
    if (start_game) begin
      div_d = STEP_DIV_W;
    end else if (move_en_d) begin
      if ({1'b0, STEP_DIV_W} <= MIN_DIV_W + slow_by) begin
        div_d = MIN_DIV_W[7:0];
      end else begin
        div_d = STEP_DIV_W - slow_by[7:0];
      end
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= STEP_DIV_W;
    end else begin
      div_q <= div_d;
    end
  end
`else
  assign div_q = STEP_DIV_W;
`endif

  // Next-state logic for the play FSM, step counter, direction and score.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    dir_d      = dir_q;
    move_en_d  = 1'b0;
    game_clr_d = 1'b0;
    score_d    = score_q;
    win_d      = win_q;

    unique case (state_q)
      S_IDLE: begin
        // Start beats a simultaneous pause. A tick in this cycle is not counted.
        if (btn_start) begin
          state_d    = S_PLAY;
          game_clr_d = 1'b1;
          cnt_d      = '0;
          pend_d     = DIR_RIGHT;
          dir_d      = DIR_RIGHT;
          win_d      = 1'b0;
          score_d    = '0;
        end
      end

      S_PLAY: begin
        score_d = score_calc;
        if (status) begin
          state_d = S_OVER;
          win_d   = 1'b0;
        end else if ({1'b0, num_squares} >= MAX_SQ_W) begin
          state_d = S_OVER;
          win_d   = 1'b1;
        end else if (btn_pause) begin
          // Counter is held so the step resumes where it left off.
          state_d = S_PAUSE;
        end else begin
          // Ticks and requests are taken only while staying in PLAY, so move_en
          // can never appear in the cycle after PLAY exits.
          if (dir_accept) begin
            pend_d = dir_req;
          end
          if (refresh_tick) begin
            if (cnt_q == div_q - 8'd1) begin
              cnt_d     = '0;
              move_en_d = 1'b1;
              dir_d     = dir_accept ? dir_req : pend_q;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
      end

      S_PAUSE: begin
        if (btn_start) begin
          state_d = S_IDLE;
        end else if (btn_pause) begin
          state_d = S_PLAY;
        end
      end

      S_OVER: begin
        if (btn_start) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight move_en.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the synthesized flops.
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_q     <= DIR_RIGHT;
      dir_q      <= DIR_RIGHT;
      move_en_q  <= 1'b0;
      game_clr_q <= 1'b0;
      score_q    <= '0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      dir_q      <= dir_d;
      move_en_q  <= move_en_d;
      game_clr_q <= game_clr_d;
      score_q    <= score_d;
      win_q      <= win_d;
    end
  end

  assign move_en  = move_en_q;
  assign dir      = dir_q;
  assign game_clr = game_clr_q;
  assign state    = state_q;
  assign score    = score_q;
  assign win      = win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench for game_ctrl.
// The stimulus side runs a rule-level game model each cycle. Whenever the
// model's visible outputs change, or a pulse is due, it queues a cycle-stamped
// expectation. A monitor samples the DUT 1 time unit after each clock edge.
// Whenever the DUT's outputs change, or a pulse appears, the monitor pops and
// compares one expectation.
module tb_game_ctrl;

  localparam int STEP_DIV    = 8;
  localparam int INIT_LEN    = 3;
  localparam int MAX_SQUARES = 33;
  localparam int MIN_DIV     = 2;

  logic       clk          = 1'b0;
  logic       reset_n      = 1'b0;
  logic       refresh_tick = 1'b0;
  logic       btn_start    = 1'b0;
  logic       btn_pause    = 1'b0;
  logic       dir_valid    = 1'b0;
  logic [1:0] dir_req      = 2'd0;
  logic       status       = 1'b0;
  logic [5:0] num_squares  = 6'd3;
  logic       move_en;
  logic [1:0] dir;
  logic       game_clr;
  logic [1:0] state;
  logic [7:0] score;
  logic       win;

  game_ctrl #(
    .STEP_DIV    (STEP_DIV),
    .INIT_LEN    (INIT_LEN),
    .MAX_SQUARES (MAX_SQUARES),
    .MIN_DIV     (MIN_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset_n),
    .refresh_tick (refresh_tick),
    .btn_start    (btn_start),
    .btn_pause    (btn_pause),
    .dir_valid    (dir_valid),
    .dir_req      (dir_req),
    .status       (status),
    .num_squares  (num_squares),
    .move_en      (move_en),
    .dir          (dir),
    .game_clr     (game_clr),
    .state        (state),
    .score        (score),
    .win          (win)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] state;
    logic [7:0] score;
    logic       win;
    logic       game_clr;
    logic       move_en;
    logic [1:0] dir;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  localparam obs_t RST_OBS = {2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd1};

  typedef enum int {M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_OVER = 3} mode_e;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_moves  = 0;
  int         ns_v;

  // Reference model state
  mode_e      m_mode;
  int         m_ticks;
  int         m_div;
  logic [1:0] m_pend;
  obs_t       m_obs;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_ticks = 0;
    m_div   = STEP_DIV;
    m_pend  = 2'd1;
    m_obs   = RST_OBS;
  endtask

  // One clock of the game rules, applied to the inputs presented this cycle.
  task automatic model_cycle(input logic s, input logic p, input logic t,
                             input logic v, input logic [1:0] dr,
                             input logic st, input int ns);
    obs_t nxt;
    int   old_score;
    int   sc;
`ifdef SPEEDUP_EN
    int   nd;
`endif
    nxt          = m_obs;
    nxt.move_en  = 1'b0;
    nxt.game_clr = 1'b0;
    old_score    = int'(m_obs.score);
    case (m_mode)
      M_IDLE: begin
        if (s) begin
          m_mode       = M_PLAY;
          nxt.game_clr = 1'b1;
          m_ticks      = 0;
          m_div        = STEP_DIV;
          m_pend       = 2'd1;
          nxt.dir      = 2'd1;
          nxt.win      = 1'b0;
          nxt.score    = 8'd0;
        end
      end
      M_PLAY: begin
        sc = ns - INIT_LEN;
        if (sc < 0) sc = 0;
        if (sc > 255) sc = 255;
        nxt.score = 8'(sc);
        if (st) begin
          m_mode  = M_OVER;
          nxt.win = 1'b0;
        end else if (ns >= MAX_SQUARES) begin
          m_mode  = M_OVER;
          nxt.win = 1'b1;
        end else if (p) begin
          m_mode = M_PAUSE;
        end else begin
          if (v && int'(dr) != (int'(m_obs.dir) + 2) % 4) m_pend = dr;
          if (t) begin
            m_ticks++;
            if (m_ticks == m_div) begin
              m_ticks     = 0;
              nxt.move_en = 1'b1;
              nxt.dir     = m_pend;
`ifdef SPEEDUP_EN
              nd    = STEP_DIV - old_score / 8;
              m_div = (nd < MIN_DIV) ? MIN_DIV : nd;
`endif
            end
          end
        end
      end
      M_PAUSE: begin
        if (s) m_mode = M_IDLE;
        else if (p) m_mode = M_PLAY;
      end
      M_OVER: begin
        if (s) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    nxt.state = 2'(m_mode);
    if (nxt != m_obs || nxt.move_en || nxt.game_clr) sb_q.push_back('{cyc + 1, nxt});
    m_obs = nxt;
  endtask

  // Present one cycle of inputs at the falling edge and advance the model.
  task automatic drive(input logic s, input logic p, input logic t,
                       input logic v, input logic [1:0] dr, input logic st);
    @(negedge clk);
    btn_start    = s;
    btn_pause    = p;
    refresh_tick = t;
    dir_valid    = v;
    dir_req      = dr;
    status       = st;
    num_squares  = 6'(ns_v);
    model_cycle(s, p, t, v, dr, st, ns_v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare each visible DUT output event against the scoreboard.
  initial begin
    obs_t prev;
    obs_t cur;
    exp_t e;
    prev = RST_OBS;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        prev = RST_OBS;
        continue;
      end
      cur = {state, score, win, game_clr, move_en, dir};
      if (cur.move_en) n_moves++;
      if (cur != prev || cur.move_en || cur.game_clr) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_event cyc=%0d: st=%0d sc=%0d win=%0b clr=%0b mv=%0b dir=%0d, expected no change",
                   cyc, cur.state, cur.score, cur.win, cur.game_clr, cur.move_en, cur.dir);
        end else begin
          e = sb_q.pop_front();
          if (cur !== e.o || cyc != e.cyc) begin
            n_errors++;
            $display("FAIL event cyc=%0d: got st=%0d sc=%0d win=%0b clr=%0b mv=%0b dir=%0d, expected cyc=%0d st=%0d sc=%0d win=%0b clr=%0b mv=%0b dir=%0d",
                     cyc, cur.state, cur.score, cur.win, cur.game_clr, cur.move_en, cur.dir,
                     e.cyc, e.o.state, e.o.score, e.o.win, e.o.game_clr, e.o.move_en, e.o.dir);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int m0;
    logic s, p, t, v, st;
    logic [1:0] dr;

    ns_v = INIT_LEN;
    model_reset();

    // Reset held low for 20 ns, then released.
    #20 reset_n = 1'b1;
    #1;
    check("rst_state", int'(state), 0);
    check("rst_dir", int'(dir), 1);
    check("rst_move_en", int'(move_en), 0);
    check("rst_game_clr", int'(game_clr), 0);
    check("rst_score", int'(score), 0);
    check("rst_win", int'(win), 0);

    // Start with pause and a tick in the same cycle: start wins, the tick is not counted.
    m0 = n_moves;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    sample();
    check("start_state", int'(state), 1);
    check("start_game_clr", int'(game_clr), 1);
    idle(1);
    sample();
    check("game_clr_one_cycle", int'(game_clr), 0);
    ticks(16);
    idle(2);
    check("moves_after_16_ticks", n_moves - m0, 16 / STEP_DIV);

    // Reverse request dropped; the last accepted request is applied at the next move.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    sample();
    check("reverse_dropped", int'(dir), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    sample();
    check("dir_stable_until_move", int'(dir), 1);
    ticks(STEP_DIV);
    idle(1);
    check("dir_after_move", int'(dir), 2);

    // Pause holds the step counter.
    ticks(5);
    m0 = n_moves;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    sample();
    check("paused_state", int'(state), 2);
    ticks(20);
    check("no_moves_in_pause", n_moves - m0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    sample();
    check("resumed_state", int'(state), 1);
    ticks(2);
    check("no_move_before_resume_step", n_moves - m0, 0);
    ticks(1);
    idle(1);
    check("move_after_resume_step", n_moves - m0, 1);

    // Collision ends the game as a loss; the score holds through IDLE.
    ns_v = 7;
    idle(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    sample();
    check("collision_state", int'(state), 3);
    check("collision_win", int'(win), 0);
    check("collision_score", int'(score), 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    sample();
    check("over_to_idle", int'(state), 0);
    check("score_held_in_idle", int'(score), 4);
    ns_v = INIT_LEN;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    sample();
    check("restart_state", int'(state), 1);
    check("restart_score", int'(score), 0);

    // Win check beats a simultaneous pause.
    ns_v = MAX_SQUARES;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    sample();
    check("win_state", int'(state), 3);
    check("win_flag", int'(win), 1);
    check("win_score", int'(score), MAX_SQUARES - INIT_LEN);
    ns_v = INIT_LEN;

    // Reset asserted while a move_en is in flight discards it.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    ticks(STEP_DIV - 1);
    m0 = n_moves;
    @(negedge clk);
    refresh_tick = 1'b1;
    #2 reset_n = 1'b0;
    sb_q.delete();
    model_reset();
    @(negedge clk);
    refresh_tick = 1'b0;
    reset_n      = 1'b1;
    #1;
    check("midstep_rst_state", int'(state), 0);
    check("midstep_rst_move_en", int'(move_en), 0);
    idle(10);
    check("midstep_move_discarded", n_moves - m0, 0);

    // Randomised play against the model.
    for (int i = 0; i < 4000; i++) begin
      s  = ($urandom_range(0, 99) < 2);
      p  = ($urandom_range(0, 99) < 2);
      t  = ($urandom_range(0, 99) < 30);
      v  = ($urandom_range(0, 99) < 20);
      dr = 2'($urandom_range(0, 3));
      st = ($urandom_range(0, 999) < 5);
      if ($urandom_range(0, 99) < 8 && ns_v < 63) ns_v++;
      if ($urandom_range(0, 99) < 2) ns_v = $urandom_range(0, 36);
      drive(s, p, t, v, dr, st);
    end

    idle(5);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer for the snake-style game.
- Owns the play-state FSM (IDLE/PLAY/PAUSE/OVER) and converts the frame-rate `refresh_tick` into movement step pulses.
- Latches and filters direction requests, and issues a datapath-clear pulse on restart.
- Consumes `status` and `num_squares` from the game-status/collision datapath and produces the score and win/lose flags.

Parameters:
- STEP_DIV, 8, number of refresh_ticks per movement step in PLAY (valid range 1..255).
- INIT_LEN, 3, square count after a restart; score baseline.
- MAX_SQUARES, 33, square count that ends the game as a win.
- MIN_DIV, 2, lowest step divider reachable when SPEEDUP_EN is defined.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- refresh_tick  in  1  one-cycle pulse per video frame.
- btn_start  in  1  debounced one-cycle pulse.
- btn_pause  in  1  debounced one-cycle pulse.
- dir_valid  in  1  qualifies dir_req.
- dir_req  in  2  requested direction: 0=up, 1=right, 2=down, 3=left.
- status  in  1  from game-status datapath: 1 = collision detected.
- num_squares  in  6  current square count from datapath.
- move_en  out  1  one-cycle pulse; datapath advances one step.
- dir  out  2  direction applied at the next move_en.
- game_clr  out  1  one-cycle pulse; datapath reinitialises to INIT_LEN.
- state  out  2  0=IDLE, 1=PLAY, 2=PAUSE, 3=OVER.
- score  out  8  saturating score.
- win  out  1  1 = game ended by reaching MAX_SQUARES.

Behaviour:
- Reset values (reset=0): state=IDLE, dir=1 (right), move_en=0, game_clr=0, score=0, win=0, step counter=0, pending direction=right.
- All outputs are registered.

FSM:
- IDLE: on btn_start -> PLAY.
  - game_clr pulses in the cycle after btn_start, together with the state change.
  - Step counter cleared; dir and pending direction set to right; win cleared.
- PLAY:
  - btn_pause -> PAUSE.
  - status=1 -> OVER, win=0.
  - num_squares >= MAX_SQUARES -> OVER, win=1.
  - Priority when events coincide: status > win check > btn_pause.
- PAUSE: btn_pause -> PLAY; btn_start -> IDLE; refresh_tick, status and direction requests are ignored.
- OVER: btn_start -> IDLE. score and win hold their values until the game leaves IDLE again.

Stepping:
- Step counter counts refresh_ticks only while in PLAY.
- On the tick where counter == STEP_DIV-1: counter wraps to 0 and move_en pulses the next cycle (1-cycle latency).
- move_en is never asserted in any state other than PLAY, including the cycle in which PLAY exits.
- On pause the counter is held, not cleared.

Direction:
- A dir_valid request is stored as the pending direction unless it is the exact reverse of `dir` (up<->down, left<->right); reverse requests are dropped.
- The last valid request before a move wins.
- `dir` takes the pending value in the same cycle move_en is asserted, so the datapath always sees a stable `dir` for a whole step.

Score:
- score = num_squares - INIT_LEN, registered every cycle in PLAY.
- Clamped to 0 if num_squares < INIT_LEN; saturates at 255.

Boundary conditions:
- btn_start and btn_pause together in IDLE: start wins.
- refresh_tick in the same cycle as the transition into PLAY is not counted.
- Reset asserted mid-step: an in-flight move_en is discarded.

Optional Feature:
- Macro SPEEDUP_EN.
- Defined: the effective divider is STEP_DIV - (score >> 3), floored at MIN_DIV.
  - The new divider takes effect at the next counter wrap, never mid-count.
- Undefined: the divider is constant at STEP_DIV and MIN_DIV is unused.

Test Plan:
- Reset low 20 ns, then high; btn_start -> state=1 and game_clr high for exactly one cycle; with STEP_DIV=8, 16 refresh_ticks -> exactly 2 move_en pulses, each 1 cycle after the 8th/16th tick.
- dir=right; dir_valid with dir_req=3 (left) -> dropped, dir stays 1; then dir_req=0 followed by dir_req=2 before the next step -> dir=2 at the next move_en.
- In PLAY after 5 ticks: btn_pause -> state=2, 20 ticks produce no move_en; btn_pause again -> first move_en after 3 more ticks.
- num_squares=7, then status=1 -> state=3, win=0, score=4; btn_start -> IDLE; btn_start -> PLAY with score=0.
- num_squares=33 in the same cycle as btn_pause -> state=3, win=1, score=30 (win check beats pause).
- SPEEDUP_EN defined, num_squares=19 (score 16) -> divider 6, move_en every 6 ticks from the next wrap; num_squares=59 -> divider floors at 2.
